// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO push arbiter.
package fifo_arb_pkg;

  // Operation issued toward the FIFO control in the current cycle.
  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2
  } op_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_N_REQ = 4;
  localparam int DEF_DEPTH = 16;

endpackage

// File: rtl/fifo_push_arbiter_rr_pick.sv
// Rotate-priority picker: the first set bit of req_i at or after ptr_i,
// wrapping from N-1 to 0, is returned as a one-hot grant.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic          valid_o
);

  logic [PW-1:0] idx;
  logic          found;

  // Walk the request vector starting at the pointer; the first hit wins.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr_i) + i) % N);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Arbitrates N_REQ producers and one consumer onto a shared FIFO control
// port, issuing at most one push or one pop per cycle and tracking occupancy.
//
// Handshake: a producer raises req_i[k] (level) with its word on data_i and
// holds both until it sees gnt_o[k] high for one cycle; that cycle is the
// transfer, signalled toward the FIFO by push_o with data_o. The consumer
// holds pop_req_i high; every cycle pop_o is high is one word removed and
// also acknowledges the consumer. push_o and pop_o are never high together.
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_REQ = DEF_N_REQ,
  parameter int DEPTH = DEF_DEPTH,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = $clog2(N_REQ)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*WIDTH-1:0] data_i,
  input  logic                   pop_req_i,
  output logic [N_REQ-1:0]       gnt_o,
  output logic                   push_o,
  output logic [WIDTH-1:0]       data_o,
  output logic                   pop_o,
  output logic [CW-1:0]          cnt_o,
  output logic                   full_o,
  output logic                   empty_o,
  output op_e                    op_state_o,
  output logic [PW-1:0]          rr_ptr_o
);

  op_e              op_q, op_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;

  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] pick_gnt;
  logic             pick_valid;
  logic [PW-1:0]    pick_idx;
  logic [WIDTH-1:0] pick_data;
  logic             push_cand;
  logic             pop_cand;

  // A producer granted this cycle is still holding its request; mask it so
  // the same word is not pushed twice.
  assign eligible = req_i & ~gnt_q;

  rr_pick #(
    .N  (N_REQ),
    .PW (PW)
  ) u_pick (
    .req_i   (eligible),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (pick_gnt),
    .valid_o (pick_valid)
  );

  assign push_cand = pick_valid && (cnt_q < CW'(DEPTH));
  assign pop_cand  = pop_req_i && (cnt_q != '0);

  // Decode the one-hot pick into an index and the matching data slice.
  always_comb begin
    pick_idx  = '0;
    pick_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (pick_gnt[k]) begin
        pick_idx  = PW'(k);
        pick_data = data_i[k*WIDTH +: WIDTH];
      end
    end
  end

  // Op FSM next state: under contention, alternate, with pop first unless
  // the previous op was already a pop.
  always_comb begin
    op_d = OP_IDLE;
    if (push_cand && pop_cand) begin
      op_d = (op_q == OP_POP) ? OP_PUSH : OP_POP;
    end else if (push_cand) begin
      op_d = OP_PUSH;
    end else if (pop_cand) begin
      op_d = OP_POP;
    end
  end

  // Datapath next state driven by the chosen op.
  always_comb begin
    gnt_d    = '0;
    data_d   = data_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    case (op_d)
      OP_PUSH: begin
        gnt_d    = pick_gnt;
        data_d   = pick_data;
        cnt_d    = cnt_q + 1'b1;
        rr_ptr_d = (pick_idx == PW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
      end
      OP_POP: begin
        cnt_d = cnt_q - 1'b1;
      end
      default: ;
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      op_q     <= OP_IDLE;
      gnt_q    <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      op_q     <= op_d;
      gnt_q    <= gnt_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign gnt_o      = gnt_q;
  assign push_o     = (op_q == OP_PUSH);
  assign pop_o      = (op_q == OP_POP);
  assign data_o     = data_q;
  assign cnt_o      = cnt_q;
  assign full_o     = (cnt_q == CW'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign op_state_o = op_q;
  assign rr_ptr_o   = rr_ptr_q;

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench for fifo_push_arbiter: expected push/pop events are queued
// as stimulus is issued and matched by a monitor on each strobe.
module tb_fifo_push_arbiter;
  import fifo_arb_pkg::*;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int D  = 16;
  localparam int CW = $clog2(D + 1);
  localparam int PW = $clog2(N);
  localparam int EW = 2 + N + W + CW;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [N-1:0]     req_i;
  logic [N*W-1:0]   data_i;
  logic             pop_req_i;
  logic [N-1:0]     gnt_o;
  logic             push_o;
  logic [W-1:0]     data_o;
  logic             pop_o;
  logic [CW-1:0]    cnt_o;
  logic             full_o;
  logic             empty_o;
  op_e              op_state_o;
  logic [PW-1:0]    rr_ptr_o;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  fifo_push_arbiter #(.WIDTH(W), .N_REQ(N), .DEPTH(D)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_i      (req_i),
    .data_i     (data_i),
    .pop_req_i  (pop_req_i),
    .gnt_o      (gnt_o),
    .push_o     (push_o),
    .data_o     (data_o),
    .pop_o      (pop_o),
    .cnt_o      (cnt_o),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .op_state_o (op_state_o),
    .rr_ptr_o   (rr_ptr_o)
  );

  // Clock
  always #5 clk_i = ~clk_i;

  function automatic logic [W-1:0] dval(int k);
    return W'(32'hC0DE_0000 + k * 32'h0000_0101);
  endfunction

  task automatic exp_push(int k, int c);
    exp_q.push_back({2'd1, N'(1 << k), dval(k), CW'(c)});
  endtask

  task automatic exp_pop(int c);
    exp_q.push_back({2'd2, N'(0), W'(0), CW'(c)});
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Monitor: every strobe must match the head of the expected queue.
  always @(negedge clk_i) begin : mon
    logic [EW-1:0] act_v;
    logic [EW-1:0] exp_v;
    if (rst_i) begin
      checks++;
      if (push_o && pop_o) begin
        errors++;
        $display("FAIL push_pop_overlap: push_o=%0b pop_o=%0b expected not both", push_o, pop_o);
      end
      if (push_o || pop_o) begin
        act_v = {(push_o ? 2'd1 : 2'd2), gnt_o, (push_o ? data_o : W'(0)), cnt_o};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: got %0h expected none", act_v);
        end else begin
          exp_v = exp_q.pop_front();
          if (act_v !== exp_v) begin
            errors++;
            $display("FAIL strobe_event: got %0h expected %0h", act_v, exp_v);
          end
        end
      end else if (gnt_o != '0) begin
        errors++;
        $display("FAIL stray_grant: got %0b expected 0", gnt_o);
      end
    end
  end

  initial begin
    rst_i     = 1'b0;
    req_i     = 4'hF;
    pop_req_i = 1'b0;
    for (int k = 0; k < N; k++) data_i[k*W +: W] = dval(k);

    // Reset held with all requests up: everything quiet.
    #2;
    tick(2);
    chk("rst_gnt",   64'(gnt_o),  64'(0));
    chk("rst_push",  64'(push_o), 64'(0));
    chk("rst_pop",   64'(pop_o),  64'(0));
    chk("rst_data",  64'(data_o), 64'(0));
    chk("rst_cnt",   64'(cnt_o),  64'(0));
    chk("rst_empty", 64'(empty_o), 64'(1));
    chk("rst_full",  64'(full_o), 64'(0));
    chk("rst_state", 64'(op_state_o), 64'(OP_IDLE));
    chk("rst_rr",    64'(rr_ptr_o), 64'(0));

    // Round-robin from pointer 0 with all producers requesting.
    exp_push(0, 1); exp_push(1, 2); exp_push(2, 3); exp_push(3, 4); exp_push(0, 5);
    rst_i = 1'b1;
    tick(5);
    req_i = '0;
    tick(2);
    chk("rr_cnt", 64'(cnt_o), 64'(5));
    chk("rr_ptr", 64'(rr_ptr_o), 64'(1));

    // Contention at occupancy 5: pop first, then strict alternation.
    for (int i = 0; i < 3; i++) begin
      exp_pop(4);
      exp_push(0, 5);
    end
    req_i     = 4'b0001;
    pop_req_i = 1'b1;
    tick(6);
    req_i     = '0;
    pop_req_i = 1'b0;
    tick(1);
    chk("cont_cnt", 64'(cnt_o), 64'(5));

    // Drain to empty; further pop requests must not underflow.
    for (int c = 4; c >= 0; c--) exp_pop(c);
    pop_req_i = 1'b1;
    tick(7);
    chk("empty_flag", 64'(empty_o), 64'(1));
    chk("empty_cnt",  64'(cnt_o),   64'(0));
    chk("empty_pop",  64'(pop_o),   64'(0));

    // Single push while the consumer waits: one push then one pop.
    exp_push(2, 1);
    exp_pop(0);
    req_i = 4'b0100;
    tick(1);
    req_i = '0;
    tick(2);
    pop_req_i = 1'b0;
    chk("single_cnt", 64'(cnt_o), 64'(0));
    chk("single_rr",  64'(rr_ptr_o), 64'(3));

    // Fill to DEPTH starting from pointer 3.
    for (int i = 0; i < D; i++) exp_push((3 + i) % N, i + 1);
    req_i = 4'hF;
    tick(D);
    req_i = 4'b0100;
    tick(3);
    chk("full_cnt",  64'(cnt_o),  64'(D));
    chk("full_flag", 64'(full_o), 64'(1));
    chk("full_push", 64'(push_o), 64'(0));

    // One pop frees a slot; the blocked request is then granted.
    exp_pop(D - 1);
    exp_push(2, D);
    pop_req_i = 1'b1;
    tick(1);
    pop_req_i = 1'b0;
    tick(1);
    req_i = '0;
    tick(1);
    chk("refill_cnt", 64'(cnt_o), 64'(D));

    // Asynchronous reset while a push strobe is high.
    exp_pop(D - 1);
    pop_req_i = 1'b1;
    tick(1);
    pop_req_i = 1'b0;
    req_i     = 4'b0001;
    tick(1);
    chk("pre_rst_push", 64'(push_o), 64'(1));
    chk("pre_rst_cnt",  64'(cnt_o),  64'(D));
    #1 rst_i = 1'b0;
    #1;
    chk("arst_push",  64'(push_o),   64'(0));
    chk("arst_cnt",   64'(cnt_o),    64'(0));
    chk("arst_gnt",   64'(gnt_o),    64'(0));
    chk("arst_rr",    64'(rr_ptr_o), 64'(0));
    chk("arst_data",  64'(data_o),   64'(0));
    chk("arst_state", 64'(op_state_o), 64'(OP_IDLE));

    // First decision after release grants producer 0.
    tick(1);
    exp_push(0, 1);
    rst_i = 1'b1;
    tick(1);
    req_i = '0;
    tick(2);

    // Bounded wait for the monitor to consume everything.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(1);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
